// File: rtl/keypad_sequencer.sv
// rtl/keypad_sequencer.sv - keypad entry FSM producing A, OP, B and enable E for the operator
module keypad_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  output logic [3:0] A,
  output logic [3:0] OP,
  output logic [3:0] B,
  output logic       E,
  output logic [2:0] state,
  output logic       key_err
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EQ   = 3'd3,
    S_SHOW = 3'd4
  } st_t;

  localparam logic [3:0] K_ADD  = 4'b1100;
  localparam logic [3:0] K_EQ   = 4'b1101;
  localparam logic [3:0] K_CLR  = 4'b1110;
  localparam logic [3:0] K_NONE = 4'b1111;

  // A zero timeout disables the auto-clear entirely.
  localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  st_t              st;
  logic             key_prev;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic is_digit;
  logic is_op;
  logic is_eq;
  logic is_clr;
  logic partial;
  logic timeout_hit;

  // The "none" code never counts as a key, so it cannot disturb state or timer.
  assign accept      = key_pressed && !key_prev && (key_code != K_NONE);
  assign is_digit    = (key_code <= 4'd9);
  assign is_op       = (key_code >= 4'b1010) && (key_code <= K_ADD);
  assign is_eq       = (key_code == K_EQ);
  assign is_clr      = (key_code == K_CLR);
  assign partial     = (st == S_OP) || (st == S_B) || (st == S_EQ);
  assign timeout_hit = TO_EN && partial && !accept && (cnt == TO_LAST);

  assign state = st;

  // Entry FSM, edge detector and inactivity timer; a key in the firing cycle beats the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_A;
      A        <= 4'd0;
      B        <= 4'd0;
      OP       <= K_ADD;
      E        <= 1'b0;
      key_err  <= 1'b0;
      cnt      <= '0;
      key_prev <= 1'b1;
    end else begin
      key_prev <= key_pressed;
      key_err  <= 1'b0;

      if (accept || timeout_hit || !partial) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if ((accept && is_clr) || timeout_hit) begin
        st <= S_A;
        A  <= 4'd0;
        B  <= 4'd0;
        OP <= K_ADD;
        E  <= 1'b0;
      end else if (accept) begin
        case (st)
          S_A: begin
            if (is_digit) begin
              A  <= key_code;
              st <= S_OP;
            end else begin
              key_err <= 1'b1;
            end
          end
          S_OP: begin
            if (is_digit) begin
              A <= key_code;
            end else if (is_op) begin
              OP <= key_code;
              st <= S_B;
            end else begin
              key_err <= 1'b1;
            end
          end
          S_B: begin
            if (is_digit) begin
              B  <= key_code;
              st <= S_EQ;
            end else if (is_op) begin
              OP <= key_code;
            end else begin
              key_err <= 1'b1;
            end
          end
          S_EQ: begin
            if (is_digit) begin
              B <= key_code;
            end else if (is_eq) begin
              E  <= 1'b1;
              st <= S_SHOW;
            end else begin
              key_err <= 1'b1;
            end
          end
          S_SHOW: begin
            // A new digit starts the next calculation, keeping the previous operator.
            if (is_digit) begin
              A  <= key_code;
              B  <= 4'd0;
              E  <= 1'b0;
              st <= S_OP;
            end else if (is_op) begin
              key_err <= 1'b1;
            end
          end
          default: begin
            st <= S_A;
            A  <= 4'd0;
            B  <= 4'd0;
            OP <= K_ADD;
            E  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_sequencer.md
Name: keypad_sequencer

Overview:
- Front-end stage of the 4-bit calculator; sits directly upstream of the arithmetic operator block.
- Turns a stream of keypad codes into the operand A, the operator code OP and operand B, then raises the enable E that the operator uses to compute its 8-bit result.
- Owns the entry state machine, key edge detection, error flagging and the inactivity timeout.

Parameters:
TIMEOUT_CYCLES, 50000000, idle cycles in a partial-entry state before an automatic clear (1 s at 50 MHz); 0 disables the timeout
CNT_W, 26, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
key_pressed  in  1  level from keypad decoder (already synchronised), high while a key is held
key_code  in  4  code of held key: 0-9 digit, 1010 mul, 1011 sub, 1100 add, 1101 equals, 1110 clear, 1111 none
A  out  4  operand A to operator
OP  out  4  operator code to operator (1010/1011/1100 only)
B  out  4  operand B to operator
E  out  1  operator enable
state  out  3  current FSM state (for display/debug)
key_err  out  1  one-cycle pulse on a key illegal in the current state

Behaviour:
- Single clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: A=0, B=0, OP=1100, E=0, key_err=0, state=S_A, timeout counter=0, key_prev=1.
- Key accept: a key is accepted in a cycle where key_pressed=1 and key_prev=0. key_code is sampled in that cycle. key_prev <= key_pressed every cycle.
- key_prev resets to 1, so a key held through reset release is not accepted until it is released and pressed again.
- Outputs and state update on the clock edge that ends the accepting cycle (latency 1). key_err is high for exactly that one cycle.
- Code 1111 is ignored in every state, with no error.
- States (encoding): S_A=0, S_OP=1, S_B=2, S_EQ=3, S_SHOW=4.
- S_A:
  - digit: A=digit, go to S_OP.
  - operator or equals: key_err, stay.
- S_OP:
  - digit: overwrite A, stay.
  - operator: OP=code, go to S_B.
  - equals: key_err, stay.
- S_B:
  - digit: B=digit, go to S_EQ.
  - operator: overwrite OP, stay.
  - equals: key_err, stay.
- S_EQ:
  - digit: overwrite B, stay.
  - operator: key_err, stay.
  - equals: E=1, go to S_SHOW.
- S_SHOW:
  - E held at 1 for the whole state.
  - digit: A=digit, B=0, E=0, OP unchanged, go to S_OP.
  - operator: key_err, stay with E=1.
  - equals: no change, no error.
- Clear (1110), any state: A=0, B=0, OP=1100, E=0, go to S_A, no error.
- E is 1 only in S_SHOW. A, OP and B are stable whenever E=1.
- Timeout counter:
  - Counts only in S_OP, S_B and S_EQ; zeroed on every accepted key and in any other state.
  - When counter == TIMEOUT_CYCLES-1 with no accepted key that cycle, perform the clear action.
  - If a key is accepted in the same cycle, the key wins and the counter zeroes.
  - TIMEOUT_CYCLES=0: never fires.
- Reset mid-entry or in S_SHOW: takes priority over every key and timeout; all reset values apply at that edge.

Test Plan:
1. Press 7, add(1100), 5, equals as separate edges -> A=7, OP=1100, B=5, E=1 one cycle after equals edge; state=4; operator result reads 12.
2. Press 3, mul(1010), sub(1011), 9, equals -> OP=1011 (last operator wins); A=3, B=9, E=1; no key_err.
3. From S_A press add, then from S_EQ press mul -> key_err high for exactly 1 cycle each; state stays 0 and 3 respectively.
4. Hold key 4 for 10 cycles -> only one acceptance, A=4, state=1. Assert reset while key 4 held, release reset -> no acceptance until release and repress.
5. With TIMEOUT_CYCLES=8: press 2, add, then idle -> clear on the 8th idle cycle: state=0, A=0, OP=1100. Repeat with a key edge on exactly that cycle -> key processed, no clear.
6. In S_SHOW (A=6, OP=1100, B=2), press 8 -> E=0, A=8, B=0, OP=1100, state=1. Press clear -> state=0, all operands zero.
